id_decode_core: RTL and testbench
=================================

# id_decode_core

Combinational instruction-decode core for the MIPS-style ID stage. It holds the 32×32 register file, decodes the instruction into control signals, selects the destination register, and computes the branch/jump target address. Pipeline registers, forwarding muxes and branch-condition compare sit outside this block in the ID stage.

## Interface
- Parameters: none.
- CLK  in  1  clock. Register-file write edge.
- RESET  in  1  reset: asynchronous, active-low (clock CLK). Clears the register file.
- Instr  in  32  instruction being decoded.
- Instr_PC_Plus4  in  32  PC+4 of Instr.
- JumpRegValue  in  32  rs value (already forwarded) used by jr/jalr.
- WriteReg  in  5  writeback destination.
- WriteData  in  32  writeback data.
- Write  in  1  writeback enable.
- DataA / DataB / DataC  out  32 each  values of rs, rt and DestReg.
- DestReg  out  5  destination register select.
- Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall  out  1 each  decoded control flags.
- ALUControl  out  6  ALU operation code (funct-style).
- AltPC  out  32  branch/jump target.

## Operation
- Instruction fields:
  - op = Instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0], imm = [15:0].
- R-type (op = 0):
  - Shifts, arithmetic, logic and set ops (sll, srl, sra, sllv, srlv, add, addu, sub, subu, and, or, xor, nor, slt, sltu): RegDest = 1, RegWrite = 1, ALUControl = funct.
  - jr (funct 0x08): Jump = 1, JumpRegister = 1, RegWrite = 0.
  - jalr (funct 0x09): Jump = 1, JumpRegister = 1, RegDest = 1, RegWrite = 1, ALUControl = 0x21.
  - syscall (funct 0x0C): Syscall = 1, nothing else set.
- I-type ALU ops: ALUSrc = 1, RegWrite = 1.
  - addi 0x08 → ALUControl 0x20; addiu 0x09 → 0x21; slti 0x0A → 0x2A; sltiu 0x0B → 0x2B.
  - andi 0x0C → 0x24; ori 0x0D → 0x25; xori 0x0E → 0x26; lui 0x0F → 0x3F.
  - SignOrZero = 0 for andi/ori/xori; 1 for every other op.
- Loads and stores: ALUSrc = 1, ALUControl = 0x21.
  - Loads lb, lh, lw, lbu, lhu (0x20, 0x21, 0x23, 0x24, 0x25): MemRead = 1, RegWrite = 1.
  - Stores sb, sh, sw (0x28, 0x29, 0x2B): MemWrite = 1.
- Branches: Branch = 1.
  - beq, bne, blez, bgtz (0x04–0x07).
  - REGIMM (op 0x01) with rt 0, 1, 16, 17 (bltz, bgez, bltzal, bgezal). rt 16/17 also set Link = 1, RegWrite = 1, ALUControl = 0x21.
- Jumps: j (0x02) sets Jump = 1. jal (0x03) sets Jump = 1, Link = 1, RegWrite = 1, ALUControl = 0x21.
- Unlisted opcodes/functs: all flags 0, ALUControl = 0.
- DestReg: rd if RegDest; otherwise 31 if Link; otherwise rt.
- AltPC: priority JumpRegister, then Jump, then branch.
  - JumpRegister: JumpRegValue.
  - Jump: {PC4[31:28], Instr[25:0], 2'b00}.
  - Otherwise: PC4 + (sign-extended imm << 2), 32-bit wrap.
- Register file:
  - 32 entries × 32 bits, three combinational read ports (rs, rt, DestReg).
  - Register 0 always reads 0; writes to register 0 are ignored.

## Timing
- Decode, DestReg, AltPC and read data are purely combinational; no latency.
- Write occurs on posedge CLK when Write = 1 and WriteReg ≠ 0.
- No internal write→read bypass: a read in the same cycle as a write returns the old value; the new value is visible after the edge.
- RESET low asynchronously clears all 32 registers to 0, including a reset mid-write. Writes are ignored while RESET is low.
- Combinational outputs have no reset value; they track the inputs at all times.

## Test plan
- Reset, then read all registers → DataA/B/C = 0. Write r0 = 0xFFFFFFFF → r0 still reads 0.
- Write r5 = 0x12345678 with rs = 5 in the same cycle → old value 0 before the edge, 0x12345678 after.
- Instr 0x00A62020 (add r4, r5, r6) → RegDest = 1, RegWrite = 1, DestReg = 4, ALUControl = 0x20.
- Instr 0x1000FFFF (beq), PC4 = 0x00400010 → Branch = 1, AltPC = 0x0040000C.
- Instr 0x0C100000 (jal), PC4 = 0x00400004 → Jump = 1, Link = 1, DestReg = 31, AltPC = 0x00400000.
- Instr 0x00000008 (jr) with JumpRegValue = 0x1234 → JumpRegister = 1, AltPC = 0x1234. Instr 0x0000000C → Syscall = 1, all other flags 0.

Source files
------------

// File: rtl/id_decode_core_if.sv
// Bus between the ID stage and the decode core: instruction/PC in, writeback port in,
// register read data, destination select, control flags and branch/jump target out.
interface id_decode_core_if;
    logic [31:0] Instr;
    logic [31:0] Instr_PC_Plus4;
    logic [31:0] JumpRegValue;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        Write;

    logic [31:0] DataA;
    logic [31:0] DataB;
    logic [31:0] DataC;
    logic [4:0]  DestReg;
    logic        Link;
    logic        RegDest;
    logic        Jump;
    logic        Branch;
    logic        MemRead;
    logic        MemWrite;
    logic        ALUSrc;
    logic        RegWrite;
    logic        JumpRegister;
    logic        SignOrZero;
    logic        Syscall;
    logic [5:0]  ALUControl;
    logic [31:0] AltPC;

    modport master (
        output Instr, Instr_PC_Plus4, JumpRegValue, WriteReg, WriteData, Write,
        input  DataA, DataB, DataC, DestReg, Link, RegDest, Jump, Branch, MemRead,
               MemWrite, ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall,
               ALUControl, AltPC
    );

    modport slave (
        input  Instr, Instr_PC_Plus4, JumpRegValue, WriteReg, WriteData, Write,
        output DataA, DataB, DataC, DestReg, Link, RegDest, Jump, Branch, MemRead,
               MemWrite, ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall,
               ALUControl, AltPC
    );
endinterface

// File: rtl/id_decode_core.sv
// MIPS-style ID-stage core: 32x32 register file, instruction decode, destination
// select and branch/jump target. Everything except the register write is combinational.
module id_decode_core (
    input  logic             CLK,
    input  logic             RESET,
    id_decode_core_if.slave  bus
);
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign op    = bus.Instr[31:26];
    assign rs    = bus.Instr[25:21];
    assign rt    = bus.Instr[20:16];
    assign rd    = bus.Instr[15:11];
    assign funct = bus.Instr[5:0];
    assign imm   = bus.Instr[15:0];

    logic       link, reg_dest, jump, branch, mem_read, mem_write;
    logic       alu_src, reg_write, jump_reg, sign_or_zero, syscall;
    logic [5:0] alu_ctrl;

    always_comb begin
        link         = 1'b0;
        reg_dest     = 1'b0;
        jump         = 1'b0;
        branch       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        alu_src      = 1'b0;
        reg_write    = 1'b0;
        jump_reg     = 1'b0;
        sign_or_zero = 1'b0;
        syscall      = 1'b0;
        alu_ctrl     = 6'h00;
        case (op)
            6'h00: begin
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                    6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
                        reg_dest     = 1'b1;
                        reg_write    = 1'b1;
                        alu_ctrl     = funct;
                        sign_or_zero = 1'b1;
                    end
                    6'h08: begin
                        jump         = 1'b1;
                        jump_reg     = 1'b1;
                        sign_or_zero = 1'b1;
                    end
                    6'h09: begin
                        jump         = 1'b1;
                        jump_reg     = 1'b1;
                        reg_dest     = 1'b1;
                        reg_write    = 1'b1;
                        alu_ctrl     = 6'h21;
                        sign_or_zero = 1'b1;
                    end
                    6'h0C: syscall = 1'b1;
                    default: ;
                endcase
            end
            6'h01: begin
                case (rt)
                    5'd0, 5'd1: begin
                        branch       = 1'b1;
                        sign_or_zero = 1'b1;
                    end
                    5'd16, 5'd17: begin
                        branch       = 1'b1;
                        link         = 1'b1;
                        reg_write    = 1'b1;
                        alu_ctrl     = 6'h21;
                        sign_or_zero = 1'b1;
                    end
                    default: ;
                endcase
            end
            6'h02: begin
                jump         = 1'b1;
                sign_or_zero = 1'b1;
            end
            6'h03: begin
                jump         = 1'b1;
                link         = 1'b1;
                reg_write    = 1'b1;
                alu_ctrl     = 6'h21;
                sign_or_zero = 1'b1;
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                branch       = 1'b1;
                sign_or_zero = 1'b1;
            end
            // Logical immediates zero-extend; all other immediates sign-extend.
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                alu_src      = 1'b1;
                reg_write    = 1'b1;
                sign_or_zero = !(op == 6'h0C || op == 6'h0D || op == 6'h0E);
                case (op)
                    6'h08:   alu_ctrl = 6'h20;
                    6'h09:   alu_ctrl = 6'h21;
                    6'h0A:   alu_ctrl = 6'h2A;
                    6'h0B:   alu_ctrl = 6'h2B;
                    6'h0C:   alu_ctrl = 6'h24;
                    6'h0D:   alu_ctrl = 6'h25;
                    6'h0E:   alu_ctrl = 6'h26;
                    default: alu_ctrl = 6'h3F;
                endcase
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                mem_read     = 1'b1;
                reg_write    = 1'b1;
                alu_src      = 1'b1;
                alu_ctrl     = 6'h21;
                sign_or_zero = 1'b1;
            end
            6'h28, 6'h29, 6'h2B: begin
                mem_write    = 1'b1;
                alu_src      = 1'b1;
                alu_ctrl     = 6'h21;
                sign_or_zero = 1'b1;
            end
            default: ;
        endcase
    end

    logic [4:0] dest_reg;
    assign dest_reg = reg_dest ? rd : (link ? 5'd31 : rt);

    logic [31:0] branch_off;
    assign branch_off = {{14{imm[15]}}, imm, 2'b00};

    always_comb begin
        if (jump_reg)
            bus.AltPC = bus.JumpRegValue;
        else if (jump)
            bus.AltPC = {bus.Instr_PC_Plus4[31:28], bus.Instr[25:0], 2'b00};
        else
            bus.AltPC = bus.Instr_PC_Plus4 + branch_off;
    end

    // No write-to-read bypass: reads see regs_q, which updates only at the edge.
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (bus.Write && bus.WriteReg != 5'd0)
            regs_d[bus.WriteReg] = bus.WriteData;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 32; i++)
                regs_q[i] <= 32'h0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign bus.DataA = (rs == 5'd0)       ? 32'h0 : regs_q[rs];
    assign bus.DataB = (rt == 5'd0)       ? 32'h0 : regs_q[rt];
    assign bus.DataC = (dest_reg == 5'd0) ? 32'h0 : regs_q[dest_reg];

    assign bus.DestReg      = dest_reg;
    assign bus.Link         = link;
    assign bus.RegDest      = reg_dest;
    assign bus.Jump         = jump;
    assign bus.Branch       = branch;
    assign bus.MemRead      = mem_read;
    assign bus.MemWrite     = mem_write;
    assign bus.ALUSrc       = alu_src;
    assign bus.RegWrite     = reg_write;
    assign bus.JumpRegister = jump_reg;
    assign bus.SignOrZero   = sign_or_zero;
    assign bus.Syscall      = syscall;
    assign bus.ALUControl   = alu_ctrl;
endmodule

// File: tb/tb_id_decode_core.sv
// Directed bench for id_decode_core: register-file reset/write/read behaviour and
// decode of representative instructions against hand-computed expectations.
module tb_id_decode_core;
    logic CLK;
    logic RESET;

    id_decode_core_if bus ();

    id_decode_core dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] model [32];

    logic [10:0] dut_flags;
    assign dut_flags = {bus.Link, bus.RegDest, bus.Jump, bus.Branch, bus.MemRead,
                        bus.MemWrite, bus.ALUSrc, bus.RegWrite, bus.JumpRegister,
                        bus.SignOrZero, bus.Syscall};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Order: Link RegDest Jump Branch MemRead MemWrite ALUSrc RegWrite JumpRegister SignOrZero Syscall
    function automatic logic [10:0] fl(input logic l, rg, j, b, mr, mw, as, rw, jr, sz, sc);
        return {l, rg, j, b, mr, mw, as, rw, jr, sz, sc};
    endfunction

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge CLK);
        bus.WriteReg  = a;
        bus.WriteData = d;
        bus.Write     = 1'b1;
        @(posedge CLK);
        #1;
        bus.Write = 1'b0;
        if (a != 5'd0) model[a] = d;
    endtask

    task automatic rd3(input string tag, input logic [4:0] a, b, c);
        bus.Instr = {6'h00, a, b, c, 5'h00, 6'h20};
        #1;
        check({tag, ".A"}, bus.DataA, model[a]);
        check({tag, ".B"}, bus.DataB, model[b]);
        check({tag, ".C"}, bus.DataC, model[c]);
    endtask

    task automatic dec(input string tag, input logic [31:0] instr, pc4, jrv,
                       input logic [10:0] exp_fl, input logic [5:0] exp_alu,
                       input logic [4:0] exp_dest, input logic [31:0] exp_pc);
        bus.Instr          = instr;
        bus.Instr_PC_Plus4 = pc4;
        bus.JumpRegValue   = jrv;
        #1;
        check({tag, ".flags"}, {21'h0, dut_flags}, {21'h0, exp_fl});
        check({tag, ".alu"},   {26'h0, bus.ALUControl}, {26'h0, exp_alu});
        check({tag, ".dest"},  {27'h0, bus.DestReg}, {27'h0, exp_dest});
        check({tag, ".altpc"}, bus.AltPC, exp_pc);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        RESET              = 1'b0;
        bus.Instr          = 32'h0;
        bus.Instr_PC_Plus4 = 32'h0;
        bus.JumpRegValue   = 32'h0;
        bus.WriteReg       = 5'd0;
        bus.WriteData      = 32'h0;
        bus.Write          = 1'b0;
        #3;
        rd3("rst0", 5'd1, 5'd17, 5'd31);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;

        // r0 is hardwired to zero
        wr(5'd0, 32'hFFFF_FFFF);
        rd3("r0", 5'd0, 5'd0, 5'd0);

        // same-cycle write/read returns old value, new one after the edge
        @(negedge CLK);
        bus.Instr     = {6'h00, 5'd5, 5'd0, 5'd0, 11'h020};
        bus.WriteReg  = 5'd5;
        bus.WriteData = 32'h1234_5678;
        bus.Write     = 1'b1;
        #1;
        check("r5_before", bus.DataA, 32'h0);
        @(posedge CLK);
        #1;
        bus.Write = 1'b0;
        check("r5_after", bus.DataA, 32'h1234_5678);
        model[5] = 32'h1234_5678;

        for (int i = 1; i < 32; i++) begin
            logic [7:0] b;
            b = 8'(i);
            if (i != 5) wr(5'(i), {b, ~b, b ^ 8'hC3, 8'h3C});
        end
        for (int i = 0; i < 32; i++)
            rd3("fill", 5'(i), 5'((i + 1) % 32), 5'((i + 7) % 32));

        // Write=0 must not modify
        @(negedge CLK);
        bus.WriteReg  = 5'd3;
        bus.WriteData = 32'hBAD0_BAD0;
        bus.Write     = 1'b0;
        @(posedge CLK);
        #1;
        rd3("nowr", 5'd3, 5'd3, 5'd3);

        // asynchronous reset in the middle of a write
        @(negedge CLK);
        bus.Instr     = {6'h00, 5'd9, 5'd5, 5'd1, 11'h020};
        bus.WriteReg  = 5'd9;
        bus.WriteData = 32'hCAFE_F00D;
        bus.Write     = 1'b1;
        #2;
        RESET = 1'b0;
        #1;
        check("arst.A", bus.DataA, 32'h0);
        check("arst.B", bus.DataB, 32'h0);
        check("arst.C", bus.DataC, 32'h0);
        @(posedge CLK);
        #1;
        check("arst_wr_ignored", bus.DataA, 32'h0);
        bus.Write = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 32; i += 4)
            rd3("postrst", 5'(i), 5'(i + 1), 5'(i + 2));
        wr(5'd2, 32'h0BAD_F00D);
        rd3("postrst_wr", 5'd2, 5'd0, 5'd2);

        // decode vectors
        dec("add",    32'h00A6_2020, 32'h0040_0000, 32'h0,
            fl(0,1,0,0,0,0,0,1,0,1,0), 6'h20, 5'd4,  32'h0040_8080);
        check("add.DataA", bus.DataA, 32'h0);
        dec("sub",    32'h00A6_2022, 32'h0040_0000, 32'h0,
            fl(0,1,0,0,0,0,0,1,0,1,0), 6'h22, 5'd4,  32'h0040_8088);
        dec("beq",    32'h1000_FFFF, 32'h0040_0010, 32'h0,
            fl(0,0,0,1,0,0,0,0,0,1,0), 6'h00, 5'd0,  32'h0040_000C);
        dec("beqwrap",32'h1000_0001, 32'hFFFF_FFFC, 32'h0,
            fl(0,0,0,1,0,0,0,0,0,1,0), 6'h00, 5'd0,  32'h0000_0000);
        dec("jal",    32'h0C10_0000, 32'h0040_0004, 32'h0,
            fl(1,0,1,0,0,0,0,1,0,1,0), 6'h21, 5'd31, 32'h0040_0000);
        dec("j",      32'h0800_0010, 32'hA000_0000, 32'h0,
            fl(0,0,1,0,0,0,0,0,0,1,0), 6'h00, 5'd0,  32'hA000_0040);
        dec("jr",     32'h0000_0008, 32'h0040_0000, 32'h0000_1234,
            fl(0,0,1,0,0,0,0,0,1,1,0), 6'h00, 5'd0,  32'h0000_1234);
        dec("jalr",   32'h0060_3809, 32'h0040_0000, 32'hDEAD_0000,
            fl(0,1,1,0,0,0,0,1,1,1,0), 6'h21, 5'd7,  32'hDEAD_0000);
        dec("syscall",32'h0000_000C, 32'h0040_0000, 32'h0000_1234,
            fl(0,0,0,0,0,0,0,0,0,0,1), 6'h00, 5'd0,  32'h0040_0030);
        dec("lw",     32'h8C88_0010, 32'h0040_0000, 32'h0,
            fl(0,0,0,0,1,0,1,1,0,1,0), 6'h21, 5'd8,  32'h0040_0040);
        dec("sw",     32'hAC88_0010, 32'h0040_0000, 32'h0,
            fl(0,0,0,0,0,1,1,0,0,1,0), 6'h21, 5'd8,  32'h0040_0040);
        dec("addi",   32'h20A4_FFF0, 32'h0040_0000, 32'h0,
            fl(0,0,0,0,0,0,1,1,0,1,0), 6'h20, 5'd4,  32'h003F_FFC0);
        dec("andi",   32'h3085_FFFF, 32'h0040_0000, 32'h0,
            fl(0,0,0,0,0,0,1,1,0,0,0), 6'h24, 5'd5,  32'h003F_FFFC);
        dec("lui",    32'h3C01_1234, 32'h0040_0000, 32'h0,
            fl(0,0,0,0,0,0,1,1,0,1,0), 6'h3F, 5'd1,  32'h0040_48D0);
        dec("bgezal", 32'h0411_FFFE, 32'h0040_0010, 32'h0,
            fl(1,0,0,1,0,0,0,1,0,1,0), 6'h21, 5'd31, 32'h0040_0008);
        dec("bltz",   32'h0400_0004, 32'h0040_0010, 32'h0,
            fl(0,0,0,1,0,0,0,0,0,1,0), 6'h00, 5'd0,  32'h0040_0020);
        dec("regimm2",32'h0402_0004, 32'h0040_0010, 32'h0,
            fl(0,0,0,0,0,0,0,0,0,0,0), 6'h00, 5'd2,  32'h0040_0020);
        dec("badop",  32'hFC00_0000, 32'h0040_0000, 32'h0,
            fl(0,0,0,0,0,0,0,0,0,0,0), 6'h00, 5'd0,  32'h0040_0000);
        dec("badfn",  32'h0000_0001, 32'h0040_0000, 32'h0,
            fl(0,0,0,0,0,0,0,0,0,0,0), 6'h00, 5'd0,  32'h0040_0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
